// File: rtl/toom8_pkg.sv
// Shared constants and types for the TOOM-8 multiplier datapath.
// The operand splitter and the recomposition back end both use this package.
package toom8_pkg;

    localparam int LIMB_W     = 128;
    localparam int NUM_CHUNKS = 8;
    localparam int COEFF_W    = 2 * LIMB_W + 3;
    localparam int NUM_COEFFS = 2 * NUM_CHUNKS - 1;

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    typedef logic [LIMB_W-1:0] limb_t;

endpackage

// File: rtl/toom8_recompose_if.sv
// Coefficient input stream and product output handshake of the recomposition block.
interface toom8_recompose_if #(
    parameter int LIMB_W     = toom8_pkg::LIMB_W,
    parameter int NUM_CHUNKS = toom8_pkg::NUM_CHUNKS,
    parameter int COEFF_W    = toom8_pkg::COEFF_W
);

    logic                           coeff_valid;
    logic                           coeff_ready;
    logic [COEFF_W-1:0]             coeff_data;
    logic [3:0]                     coeff_idx;
    logic                           product_valid;
    logic                           product_ready;
    logic [2*NUM_CHUNKS*LIMB_W-1:0] product;
    logic                           overflow;

    modport master (
        output coeff_valid, coeff_data, product_ready,
        input  coeff_ready, coeff_idx, product_valid, product, overflow
    );

    modport slave (
        input  coeff_valid, coeff_data, product_ready,
        output coeff_ready, coeff_idx, product_valid, product, overflow
    );

endinterface

// File: rtl/toom8_recompose_limb_adder.sv
// Combinational coefficient + running-carry adder: emits one finished limb and the carry
// into the next limb position. Kept separate so it can be pipelined later.
module toom8_limb_adder #(
    parameter int LIMB_W  = 128,
    parameter int COEFF_W = 2 * LIMB_W + 3,
    parameter int CARRY_W = COEFF_W - LIMB_W + 1
) (
    input  logic [COEFF_W-1:0] coeff,
    input  logic [CARRY_W-1:0] carry_in,
    output logic [LIMB_W-1:0]  limb,
    output logic [CARRY_W-1:0] carry_out
);

    logic [COEFF_W:0] sum;

    // One extra bit keeps coeff + carry exact; the carry never exceeds CARRY_W bits.
    assign sum       = {1'b0, coeff} + {{(COEFF_W + 1 - CARRY_W){1'b0}}, carry_in};
    assign limb      = sum[LIMB_W-1:0];
    assign carry_out = sum[COEFF_W:LIMB_W];

endmodule

// File: rtl/toom8_recompose.sv
// Recombines the 15 interpolated coefficients into the 2048-bit product, one limb per
// accepted coefficient, then flushes the final carry into the top limb.
module toom8_recompose
    import toom8_pkg::*;
#(
    parameter int LIMB_W     = toom8_pkg::LIMB_W,
    parameter int NUM_CHUNKS = toom8_pkg::NUM_CHUNKS,
    parameter int COEFF_W    = toom8_pkg::COEFF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    toom8_recompose_if.slave    bus
);

    localparam int         CARRY_W   = COEFF_W - LIMB_W + 1;
    localparam int         NUM_LIMBS = 2 * NUM_CHUNKS;
    localparam logic [3:0] LAST_IDX  = 4'(2 * NUM_CHUNKS - 2);

    state_t             state_q, state_d;
    logic [LIMB_W-1:0]  limbs [NUM_LIMBS];
    logic [CARRY_W-1:0] carry_q;
    logic [CARRY_W-1:0] carry_next;
    logic [LIMB_W-1:0]  limb_sum;
    logic [3:0]         idx_q;
    logic               ovf_q;
    logic               coeff_fire;
    logic               product_fire;

    assign coeff_fire   = bus.coeff_valid && (state_q == ACCUM);
    assign product_fire = bus.product_ready && (state_q == DONE);

    toom8_limb_adder #(
        .LIMB_W  (LIMB_W),
        .COEFF_W (COEFF_W),
        .CARRY_W (CARRY_W)
    ) u_adder (
        .coeff     (bus.coeff_data),
        .carry_in  (carry_q),
        .limb      (limb_sum),
        .carry_out (carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (coeff_fire && (idx_q == LAST_IDX)) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    if (product_fire) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Limbs are left in place between results; each is rewritten by its own coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_LIMBS; i++) begin
                limbs[i] <= '0;
            end
        end else begin
            case (state_q)
                ACCUM: begin
                    if (coeff_fire) begin
                        limbs[idx_q] <= limb_sum;
                        carry_q      <= carry_next;
                        idx_q        <= idx_q + 4'd1;
                    end
                end
                FLUSH: begin
                    limbs[NUM_LIMBS-1] <= carry_q[LIMB_W-1:0];
                    ovf_q              <= |carry_q[CARRY_W-1:LIMB_W];
                end
                DONE: begin
                    if (product_fire) begin
                        carry_q <= '0;
                        idx_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.coeff_ready   = (state_q == ACCUM);
    assign bus.product_valid = (state_q == DONE);
    assign bus.coeff_idx     = idx_q;
    assign bus.overflow      = ovf_q;

    for (genvar g = 0; g < NUM_LIMBS; g++) begin : g_product
        assign bus.product[g*LIMB_W +: LIMB_W] = limbs[g];
    end

endmodule

// File: tb/tb_toom8_recompose.sv
// Directed bench for toom8_recompose: table of coefficient sets with expected products,
// plus sequences for backpressure, gaps, mid-run reset and back-to-back results.
module tb_toom8_recompose;
    import toom8_pkg::*;

    localparam int PROD_W = 2 * NUM_CHUNKS * LIMB_W;
    localparam int BIG_W  = 2100;
    localparam int NVEC   = 5;

    typedef struct packed {
        logic [NUM_COEFFS-1:0][COEFF_W-1:0] c;
        logic [PROD_W-1:0]                  p;
        logic                               ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toom8_recompose_if bus ();

    toom8_recompose dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t  tbl [NVEC];
    string names [NVEC];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_p(input string name, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < 2 * NUM_CHUNKS; i++) begin
                if (act[i*LIMB_W +: LIMB_W] !== exp[i*LIMB_W +: LIMB_W]) begin
                    $display("FAIL %s: limb %0d got %h expected %h", name, i,
                             act[i*LIMB_W +: LIMB_W], exp[i*LIMB_W +: LIMB_W]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BIG_W-1:0] model(input vec_t v);
        logic [BIG_W-1:0] s;
        logic [BIG_W-1:0] t;
        s = '0;
        for (int k = 0; k < NUM_COEFFS; k++) begin
            t = '0;
            t[COEFF_W-1:0] = v.c[k];
            s = s + (t << (LIMB_W * k));
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " coeff_ready"}, 64'(bus.coeff_ready), 64'd1);
        chk({nm, " coeff_idx"}, 64'(bus.coeff_idx), 64'd0);
        chk({nm, " product_valid"}, 64'(bus.product_valid), 64'd0);
        chk_p({nm, " product"}, bus.product, '0);
        chk({nm, " overflow"}, 64'(bus.overflow), 64'd0);
    endtask

    // Feed one result, check latency/product/overflow, optionally stall in DONE, then take it.
    task automatic run_vec(input vec_t v, input string nm, input bit gaps, input int hold);
        int k;
        int guard;
        logic rdy;
        logic [PROD_W-1:0] snap;
        k = 0;
        guard = 0;
        while (k < NUM_COEFFS && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.coeff_valid = 1'b0;
                bus.coeff_data  = COEFF_W'($urandom);
            end else begin
                bus.coeff_valid = 1'b1;
                bus.coeff_data  = v.c[k];
            end
            rdy = bus.coeff_ready && bus.coeff_valid;
            step();
            guard++;
            if (rdy) k++;
        end
        bus.coeff_valid = 1'b0;
        chk({nm, " accepted"}, 64'(k), 64'(NUM_COEFFS));
        chk({nm, " pv in flush"}, 64'(bus.product_valid), 64'd0);
        step();
        chk({nm, " pv latency"}, 64'(bus.product_valid), 64'd1);
        chk_p({nm, " product"}, bus.product, v.p);
        chk({nm, " overflow"}, 64'(bus.overflow), 64'(v.ovf));
        snap = bus.product;
        for (int h = 0; h < hold; h++) begin
            bus.coeff_valid = 1'b1;
            bus.coeff_data  = v.c[0];
            step();
            chk({nm, " stall ready"}, 64'(bus.coeff_ready), 64'd0);
            chk({nm, " stall pv"}, 64'(bus.product_valid), 64'd1);
            chk({nm, " stall idx"}, 64'(bus.coeff_idx), 64'd15);
            chk_p({nm, " stall product"}, bus.product, snap);
            chk({nm, " stall overflow"}, 64'(bus.overflow), 64'(v.ovf));
        end
        bus.coeff_valid   = 1'b0;
        bus.product_ready = 1'b1;
        step();
        bus.product_ready = 1'b0;
        chk({nm, " post pv"}, 64'(bus.product_valid), 64'd0);
        chk({nm, " post ready"}, 64'(bus.coeff_ready), 64'd1);
        chk({nm, " post idx"}, 64'(bus.coeff_idx), 64'd0);
        chk({nm, " post overflow"}, 64'(bus.overflow), 64'd0);
    endtask

    initial begin
        int a [8];
        logic [PROD_W-1:0] abig;
        logic [BIG_W-1:0]  big;
        logic [287:0]      r;
        longint            cs;
        int                k;
        int                seen;
        int                rise [2];
        logic [PROD_W-1:0] got [2];
        logic              rdy;

        bus.coeff_valid   = 1'b0;
        bus.coeff_data    = '0;
        bus.product_ready = 1'b0;

        // Square of {a7..a0} = {8,7,6,5,4,3,2,253}
        a = '{253, 2, 3, 4, 5, 6, 7, 8};
        abig = '0;
        for (int i = 0; i < 8; i++) abig = abig | (PROD_W'(a[i]) << (LIMB_W * i));
        names[0] = "square";
        tbl[0] = '0;
        for (int kk = 0; kk < NUM_COEFFS; kk++) begin
            cs = 0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (i + j == kk) cs = cs + longint'(a[i] * a[j]);
            tbl[0].c[kk] = COEFF_W'(cs);
        end
        tbl[0].p   = abig * abig;
        tbl[0].ovf = 1'b0;

        names[1] = "carry";
        tbl[1] = '0;
        tbl[1].c[0] = '1;
        tbl[1].p[127:0]   = '1;
        tbl[1].p[255:128] = '1;
        tbl[1].p[383:256] = 128'd7;

        names[2] = "overflow";
        tbl[2] = '0;
        for (int kk = 0; kk < NUM_COEFFS; kk++) tbl[2].c[kk] = '1;
        big = model(tbl[2]);
        tbl[2].p   = big[PROD_W-1:0];
        tbl[2].ovf = 1'b1;

        names[3] = "ramp";
        tbl[3] = '0;
        for (int kk = 0; kk < NUM_COEFFS; kk++) begin
            tbl[3].c[kk] = COEFF_W'(kk + 1);
            tbl[3].p[kk*LIMB_W +: LIMB_W] = LIMB_W'(kk + 1);
        end

        names[4] = "mixed";
        tbl[4] = '0;
        for (int kk = 0; kk < NUM_COEFFS; kk++) begin
            for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
            tbl[4].c[kk] = (kk % 2 == 0) ? r[COEFF_W-1:0] : COEFF_W'(r >> (kk * 9));
        end
        big = model(tbl[4]);
        tbl[4].p   = big[PROD_W-1:0];
        tbl[4].ovf = |big[BIG_W-1:PROD_W];

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("in reset");
        rst_n = 1'b1;
        step();
        chk_reset_outputs("after reset");

        for (int i = 0; i < NVEC; i++) run_vec(tbl[i], names[i], 1'b0, 0);

        run_vec(tbl[4], "gaps_bp", 1'b1, 5);
        run_vec(tbl[0], "after_bp", 1'b0, 0);

        // Reset after c6 is accepted discards the partial result
        for (int kk = 0; kk < 7; kk++) begin
            bus.coeff_valid = 1'b1;
            bus.coeff_data  = tbl[3].c[kk];
            step();
        end
        bus.coeff_valid = 1'b0;
        chk("mid idx", 64'(bus.coeff_idx), 64'd7);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        step();
        rst_n = 1'b1;
        step();
        chk_reset_outputs("post mid reset");
        run_vec(tbl[0], "after_mid_reset", 1'b0, 0);

        // Back-to-back results with product_ready held high
        k = 0;
        seen = 0;
        rise[0] = 0;
        rise[1] = 0;
        got[0] = '0;
        got[1] = '0;
        bus.product_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && seen < 2; cyc++) begin
            bus.coeff_valid = (k < 2 * NUM_COEFFS);
            if (k < NUM_COEFFS) bus.coeff_data = tbl[0].c[k];
            else if (k < 2 * NUM_COEFFS) bus.coeff_data = tbl[3].c[k - NUM_COEFFS];
            else bus.coeff_data = '0;
            rdy = bus.coeff_valid && bus.coeff_ready;
            step();
            if (rdy) k++;
            if (bus.product_valid) begin
                got[seen]  = bus.product;
                rise[seen] = cyc;
                seen++;
            end
        end
        bus.product_ready = 1'b0;
        bus.coeff_valid   = 1'b0;
        chk("b2b results seen", 64'(seen), 64'd2);
        chk_p("b2b first product", got[0], tbl[0].p);
        chk_p("b2b second product", got[1], tbl[3].p);
        chk("b2b pulse spacing", 64'(rise[1] - rise[0]), 64'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toom8_recompose.md
# toom8_recompose

Back end of the TOOM-8 multiplier datapath. It receives the 15 interpolated coefficient products c0..c14, least-significant first, each carried on the 128-bit limb grid the splitter uses. It recombines them into the 2048-bit product, product = Σ c_k·2^(128k), with one limb-serial carry-propagating add per accepted coefficient. It hands the full product downstream through a valid/ready handshake.

## Interface
- `LIMB_W`, default 128: limb width; matches the splitter's chunk size.
- `NUM_CHUNKS`, default 8: operand chunks; the block consumes 2·NUM_CHUNKS−1 = 15 coefficients.
- `COEFF_W`, default 2·LIMB_W+3 = 259: unsigned coefficient width; each coefficient is a sum of up to 8 products of two 128-bit chunks.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `coeff_valid`, in, 1: `coeff_data` holds the next coefficient.
- `coeff_ready`, out, 1: the block accepts a coefficient this cycle.
- `coeff_data`, in, COEFF_W: coefficient c_k, unsigned.
- `coeff_idx`, out, 4: index k of the next coefficient expected (0..14).
- `product_valid`, out, 1: `product` is complete and stable.
- `product_ready`, in, 1: downstream takes the product.
- `product`, out, 2·NUM_CHUNKS·LIMB_W = 2048: recombined result.
- `overflow`, out, 1: final carry did not fit in limb 15. Sticky for the current result.

## Operation
- **Transfer rule.** A coefficient transfers on an edge where `coeff_valid && coeff_ready`. A product transfers on an edge where `product_valid && product_ready`.
- **States.** ACCUM, FLUSH, DONE. Reset state is ACCUM.
- **ACCUM** (`coeff_ready` = 1):
  - On each coefficient transfer: t = coeff_data + carry, computed COEFF_W+1 bits wide.
  - Limb k ← t[127:0]; carry ← t >> 128. The carry register is COEFF_W−LIMB_W+1 = 132 bits.
  - `coeff_idx` increments.
  - The transfer with k = 14 moves the FSM to FLUSH.
  - No transfer means no change.
- **FLUSH** (`coeff_ready` = 0, exactly one cycle):
  - Limb 15 ← carry[127:0].
  - `overflow` ← |carry[131:128].
  - Next state is DONE.
- **DONE** (`coeff_ready` = 0, `product_valid` = 1):
  - Hold `product` and `overflow` until a product transfer.
  - On the product-transfer edge: go to ACCUM; carry ← 0; `coeff_idx` ← 0; `overflow` ← 0.
- **Limb retention.** Limbs are not cleared between results. During the next accumulation, limb k is overwritten at coefficient k. `product` is meaningful only while `product_valid` = 1.
- **Input handshake.** `coeff_valid` may drop between coefficients; gaps are allowed and state holds.
- **Stalling in DONE.** Any `coeff_valid` asserted while in DONE is ignored (not accepted); upstream stalls.
- **Reset.** `rst_n` low at any time, including mid-accumulation or in DONE, immediately forces the following:
  - State ACCUM.
  - `coeff_idx`, carry, every limb, `overflow` and `product_valid` all 0.
  - `coeff_ready` = 1 once `rst_n` is high again.
  - A partial result is discarded.

## Timing
- **Reset values.** `coeff_ready` = 1, `coeff_idx` = 0, `product_valid` = 0, `product` = 0, `overflow` = 0.
- **Throughput.** One coefficient per cycle in ACCUM. Minimum 15 cycles of input, 1 FLUSH cycle, and at least 1 DONE cycle, so 17 cycles per product.
- **Latency.** `product_valid` rises at the edge one clock after the edge that transfers c14.
- **Registered outputs.** All outputs are registered or decoded from state only.
- **Backpressure.** `product_ready` has no effect outside DONE. Holding `product_ready` high gives single-cycle DONE.

## Structure
- **Shared package** `toom8_pkg` holds:
  - `LIMB_W`, `NUM_CHUNKS`, `COEFF_W`, `NUM_COEFFS` (= 15).
  - The state enum {ACCUM, FLUSH, DONE}.
  - The limb typedef.
  - The splitter uses the same package.
- **Sub-module.** One natural sub-module, `toom8_limb_adder`: a combinational COEFF_W + carry adder producing the low limb and the next carry. Isolating it lets it be pipelined later.

## Test plan
- **Reference square.** Feed the coefficients of the square of the 8-chunk operand {a7..a0} = {8,7,6,5,4,3,2,253}, i.e. c0 = 64009, c1 = 1012, … → `product` equals A² computed in the bench; `overflow` = 0; `product_valid` rises exactly 1 clock after the c14 edge.
- **Carry propagation.** c0 = 2^259−1, all other coefficients 0 → limb0 = limb1 = 2^128−1, limb2 = 7, limbs 3..15 = 0, `overflow` = 0.
- **Overflow.** All 15 coefficients = 2^259−1 → `overflow` = 1 in DONE; it clears after the product transfer.
- **Backpressure and gaps.** Random `coeff_valid` gaps plus `product_ready` held low for 5 cycles → `coeff_ready` = 0 throughout DONE, `product` stable, and the next result is correct with no lost or duplicated coefficient.
- **Reset mid-operation.** `rst_n` pulsed low after c6 is accepted → all outputs return to their reset values and `coeff_idx` = 0; a full 15-coefficient sequence afterwards yields the correct product.
- **Back-to-back results.** Two back-to-back results with `product_ready` tied high → the second product is correct and there are 17 cycles between `product_valid` pulses.
